// File: rtl/scoreboard_display_receiver.sv
// Receive side of the scoreboard scan bus: debounces each digit dwell, decodes it and
// republishes both scores after two identical complete frames. Optional macro: SCOREBOARD_RX_BLANK_ZERO_EN.
module scoreboard_display_receiver #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] segments_i,
  input  logic [3:0] segment_select_i,
  output logic [7:0] p1_score_o,
  output logic [7:0] p2_score_o,
  output logic       valid_o,
  output logic       locked_o,
  output logic       error_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [SW-1:0] STABLE_W  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT_CYCLES);

  logic [3:0]    sel_q, sel_prev;
  logic [6:0]    seg_q, seg_prev;
  logic [SW-1:0] stab_cnt, stab_next;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    digit_q [4];
  logic [3:0]    mask_q;
  logic [15:0]   prev_cand_q;
  logic          prev_valid_q;
  logic          pub_req_q;
  logic [15:0]   pub_cand_q;

  logic          one_hot;
  logic          same;
  logic          capture;
  logic [1:0]    slot;
  logic          is_tens;
  logic [3:0]    digit_val;
  logic          legal;
  logic [3:0]    mask_cap;
  logic [3:0]    d [4];
  logic [15:0]   cand;
  logic          complete;
  logic          idle_hit;

  assign one_hot = (sel_q != 4'd0) && ((sel_q & (sel_q - 4'd1)) == 4'd0);
  assign same    = ({sel_q, seg_q} == {sel_prev, seg_prev});
  assign is_tens = sel_q[3] | sel_q[1];

  // Dwell length in registered samples; a non-one-hot select never counts
  always_comb begin
    stab_next = '0;
    if (!one_hot)
      stab_next = '0;
    else if (!same)
      stab_next = SW'(1);
    else if (stab_cnt >= STABLE_W)
      stab_next = stab_cnt;
    else
      stab_next = stab_cnt + 1'b1;
  end

  assign capture  = one_hot && (stab_next == STABLE_W) && !(same && (stab_cnt == STABLE_W));
  assign idle_hit = !capture && (idle_cnt == TIMEOUT_W - 1'b1);

  always_comb begin
    slot = 2'd0;
    case (sel_q)
      4'b1000: slot = 2'd3;
      4'b0100: slot = 2'd2;
      4'b0010: slot = 2'd1;
      4'b0001: slot = 2'd0;
      default: slot = 2'd0;
    endcase
  end

  always_comb begin
    digit_val = 4'd0;
    legal     = 1'b1;
    case (seg_q)
      7'h7E: digit_val = 4'd0;
      7'h30: digit_val = 4'd1;
      7'h6D: digit_val = 4'd2;
      7'h79: digit_val = 4'd3;
      7'h33: digit_val = 4'd4;
      7'h5B: digit_val = 4'd5;
      7'h5F: digit_val = 4'd6;
      7'h70: digit_val = 4'd7;
      7'h7F: digit_val = 4'd8;
      7'h7B: digit_val = 4'd9;
`ifdef SCOREBOARD_RX_BLANK_ZERO_EN
      // Leading-zero suppression on a tens digit reads as zero
      7'h00: legal = is_tens;
`else
      7'h00: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
  end

  // Re-capturing a slot already in the frame starts a fresh frame from that slot
  always_comb begin
    mask_cap = mask_q[slot] ? (4'b0001 << slot) : (mask_q | (4'b0001 << slot));
    for (int i = 0; i < 4; i++)
      d[i] = (slot == 2'(i)) ? digit_val : digit_q[i];
    cand[15:8] = 8'(d[3]) * 8'd10 + 8'(d[2]);
    cand[7:0]  = 8'(d[1]) * 8'd10 + 8'(d[0]);
    complete   = legal && (mask_cap == 4'hF);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q        <= '0;
      seg_q        <= '0;
      sel_prev     <= '0;
      seg_prev     <= '0;
      stab_cnt     <= '0;
      idle_cnt     <= '0;
      for (int i = 0; i < 4; i++)
        digit_q[i] <= '0;
      mask_q       <= '0;
      prev_cand_q  <= '0;
      prev_valid_q <= 1'b0;
      pub_req_q    <= 1'b0;
      pub_cand_q   <= '0;
      p1_score_o   <= '0;
      p2_score_o   <= '0;
      valid_o      <= 1'b0;
      locked_o     <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      sel_q     <= segment_select_i;
      seg_q     <= segments_i;
      sel_prev  <= sel_q;
      seg_prev  <= seg_q;
      stab_cnt  <= stab_next;
      valid_o   <= 1'b0;
      error_o   <= 1'b0;
      pub_req_q <= 1'b0;

      if (capture) begin
        idle_cnt <= '0;
        if (!legal) begin
          error_o <= 1'b1;
          mask_q  <= '0;
        end else begin
          digit_q[slot] <= digit_val;
          if (complete) begin
            mask_q       <= '0;
            prev_cand_q  <= cand;
            prev_valid_q <= 1'b1;
            pub_req_q    <= prev_valid_q && (prev_cand_q == cand);
            pub_cand_q   <= cand;
          end else begin
            mask_q <= mask_cap;
          end
        end
      end else if (idle_hit) begin
        // Scan lost: forget frame history but keep showing the last scores
        idle_cnt     <= TIMEOUT_W;
        mask_q       <= '0;
        prev_cand_q  <= '0;
        prev_valid_q <= 1'b0;
        locked_o     <= 1'b0;
      end else if (idle_cnt != TIMEOUT_W) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (pub_req_q) begin
        locked_o <= 1'b1;
        if (pub_cand_q != {p1_score_o, p2_score_o}) begin
          p1_score_o <= pub_cand_q[15:8];
          p2_score_o <= pub_cand_q[7:0];
          valid_o    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_display_receiver.sv
// Self-checking bench for scoreboard_display_receiver: directed dwell tables plus
// randomized scan frames checked against a frame-level score model.
module tb_scoreboard_display_receiver;

  localparam int STABLE = 2;
  localparam int TO     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] segments;
  logic [3:0] segment_select;
  logic [7:0] p1_score, p2_score;
  logic       valid, locked, error;

  scoreboard_display_receiver #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .segments_i(segments), .segment_select_i(segment_select),
    .p1_score_o(p1_score), .p2_score_o(p2_score), .valid_o(valid), .locked_o(locked),
    .error_o(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    int         len;
    int         p1;
    int         p2;
    int         lk;
    int         nv;
    int         ne;
  } row_t;

  row_t       tab[$];
  logic [6:0] seg_tab [10];
  int tests = 0, fails = 0;
  int vcnt = 0, ecnt = 0;
  int hp1, hp2, hlk;

  int m_dig [4];
  int m_mask, m_prev, m_prev_v, m_p1, m_p2, m_lk;

  // Pulse counters: each pulse is seen once per high cycle
  always @(negedge clk) begin
    if (valid) vcnt++;
    if (error) ecnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [6:0] g, input int len);
    segment_select = s;
    segments       = g;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic run_row(input row_t r, input string tag);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    applyStimulus(r.sel, r.seg, r.len);
    checkOutput({tag, " p1"}, int'(p1_score), r.p1);
    checkOutput({tag, " p2"}, int'(p2_score), r.p2);
    checkOutput({tag, " locked"}, int'(locked), r.lk);
    checkOutput({tag, " valid pulses"}, vcnt - v0, r.nv);
    checkOutput({tag, " error pulses"}, ecnt - e0, r.ne);
  endtask

  task automatic run_table(input string tag);
    foreach (tab[i]) run_row(tab[i], $sformatf("%s row%0d", tag, i));
    tab.delete();
  endtask

  task automatic add_row(input logic [3:0] s, input logic [6:0] g, input int len, input int ne);
    tab.push_back('{s, g, len, hp1, hp2, hlk, 0, ne});
  endtask

  // One full scan; only the last dwell may change the published state
  task automatic add_frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [6:0] e, input int fp1, input int fp2, input int flk,
                           input int fv);
    add_row(4'b1000, a, 5, 0);
    add_row(4'b0100, b, 5, 0);
    add_row(4'b0010, c, 5, 0);
    tab.push_back('{4'b0001, e, 5, fp1, fp2, flk, fv, 0});
    hp1 = fp1; hp2 = fp2; hlk = flk;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    segment_select = 4'd0;
    segments = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hp1 = 0; hp2 = 0; hlk = 0;
  endtask

  task automatic m_decode(input logic [6:0] g, input bit tens, output int val, output bit ok);
    ok = 1'b0;
    val = 0;
    for (int i = 0; i < 10; i++)
      if (seg_tab[i] == g) begin ok = 1'b1; val = i; end
`ifdef SCOREBOARD_RX_BLANK_ZERO_EN
    if (g == 7'h00 && tens) begin ok = 1'b1; val = 0; end
`endif
  endtask

  // Reference: scores rebuilt from captured digits, confirmed by two equal frames
  task automatic m_step(input logic [3:0] s, input logic [6:0] g, input int len,
                        output int nv, output int ne);
    int slot, val, cand;
    bit ok;
    nv = 0;
    ne = 0;
    if ($countones(s) != 1 || len < STABLE + 1) return;
    slot = s[3] ? 3 : s[2] ? 2 : s[1] ? 1 : 0;
    m_decode(g, (slot == 3 || slot == 1), val, ok);
    if (!ok) begin
      ne = 1;
      m_mask = 0;
      return;
    end
    if (m_mask & (1 << slot)) m_mask = (1 << slot);
    else m_mask = m_mask | (1 << slot);
    m_dig[slot] = val;
    if (m_mask == 15) begin
      cand = (m_dig[3] * 10 + m_dig[2]) * 256 + (m_dig[1] * 10 + m_dig[0]);
      if (m_prev_v && cand == m_prev) begin
        m_lk = 1;
        if (cand / 256 != m_p1 || cand % 256 != m_p2) begin
          m_p1 = cand / 256;
          m_p2 = cand % 256;
          nv = 1;
        end
      end
      m_prev = cand;
      m_prev_v = 1;
      m_mask = 0;
    end
  endtask

  initial begin
    logic [3:0] s;
    logic [6:0] g, sh;
    int nv, ne, len, reps, p1, p2, pick, vals[4];
    bit ok;
    int dummy;
    row_t r;

    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    vals = '{42, 7, 99, 0};

    do_reset();
    checkOutput("reset p1", int'(p1_score), 0);
    checkOutput("reset p2", int'(p2_score), 0);
    checkOutput("reset locked", int'(locked), 0);
    checkOutput("reset valid", int'(valid), 0);
    checkOutput("reset error", int'(error), 0);

    // 42/07 twice publishes, third identical frame is silent, then 12 -> 13 -> 13
    add_frame(7'h33, 7'h6D, 7'h7E, 7'h70, 0, 0, 0, 0);
    add_frame(7'h33, 7'h6D, 7'h7E, 7'h70, 42, 7, 1, 1);
    add_frame(7'h33, 7'h6D, 7'h7E, 7'h70, 42, 7, 1, 0);
    add_frame(7'h30, 7'h6D, 7'h7E, 7'h70, 42, 7, 1, 0);
    add_frame(7'h30, 7'h79, 7'h7E, 7'h70, 42, 7, 1, 0);
    add_frame(7'h30, 7'h79, 7'h7E, 7'h70, 13, 7, 1, 1);
    // Illegal P1 ones pattern discards the frame; needs two clean frames after
    add_row(4'b1000, 7'h5B, 5, 0);
    add_row(4'b0100, 7'h01, 5, 1);
    add_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 13, 7, 1, 0);
    add_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 55, 55, 1, 1);
    // Multi-hot select and a too-short dwell must be ignored silently
    for (int k = 0; k < 2; k++) begin
      add_row(4'b1000, 7'h30, 5, 0);
      add_row(4'b0100, 7'h7E, 5, 0);
      add_row(4'b0110, 7'h7E, 5, 0);
      add_row(4'b0010, 7'h7E, 5, 0);
      add_row(4'b0001, 7'h6D, STABLE - 1, 0);
      if (k == 0) add_row(4'b0001, 7'h5B, 5, 0);
      else tab.push_back('{4'b0001, 7'h5B, 5, 10, 5, 1, 1, 0});
    end
    hp1 = 10; hp2 = 5; hlk = 1;
    run_table("dir");

    // Scan stops: lock held just before timeout, dropped after, scores kept
    applyStimulus(4'd0, 7'd0, TO - 10);
    checkOutput("pre-timeout locked", int'(locked), 1);
    applyStimulus(4'd0, 7'd0, 20);
    checkOutput("timeout locked", int'(locked), 0);
    checkOutput("timeout p1 held", int'(p1_score), 10);
    checkOutput("timeout p2 held", int'(p2_score), 5);
    hlk = 0;
    add_frame(7'h30, 7'h7E, 7'h7E, 7'h5B, 10, 5, 0, 0);
    add_frame(7'h30, 7'h7E, 7'h7E, 7'h5B, 10, 5, 1, 0);
    run_table("relock");

`ifdef SCOREBOARD_RX_BLANK_ZERO_EN
    add_frame(7'h79, 7'h79, 7'h00, 7'h5B, 10, 5, 1, 0);
    add_frame(7'h79, 7'h79, 7'h00, 7'h5B, 33, 5, 1, 1);
`else
    add_row(4'b1000, 7'h79, 5, 0);
    add_row(4'b0100, 7'h79, 5, 0);
    add_row(4'b0010, 7'h00, 5, 1);
    add_row(4'b0001, 7'h5B, 5, 0);
`endif
    run_table("blank");

    // Reset in the middle of a frame
    applyStimulus(4'b1000, 7'h30, 5);
    applyStimulus(4'b0100, 7'h30, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset p1", int'(p1_score), 0);
    checkOutput("midreset p2", int'(p2_score), 0);
    checkOutput("midreset locked", int'(locked), 0);
    checkOutput("midreset valid", int'(valid), 0);
    checkOutput("midreset error", int'(error), 0);
    rst = 1'b0;
    hp1 = 0; hp2 = 0; hlk = 0;
    add_row(4'b0010, 7'h7E, 5, 0);
    add_row(4'b0001, 7'h5B, 5, 0);
    run_table("postreset");

    // Randomized scanning against the frame model
    do_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_mask = 0; m_prev = 0; m_prev_v = 0; m_p1 = 0; m_p2 = 0; m_lk = 0;
    for (int f = 0; f < 40; f++) begin
      p1 = vals[$urandom_range(0, 3)];
      p2 = vals[$urandom_range(0, 3)];
      reps = $urandom_range(1, 3);
      for (int rp = 0; rp < reps; rp++) begin
        for (int sl = 3; sl >= 0; sl--) begin
          s = 4'(1 << sl);
          case (sl)
            3: pick = p1 / 10;
            2: pick = p1 % 10;
            1: pick = p2 / 10;
            default: pick = p2 % 10;
          endcase
          g = seg_tab[pick];
          if ($urandom_range(0, 11) == 0) begin
            do begin
              g = 7'($urandom_range(1, 127));
              m_decode(g, 1'b0, dummy, ok);
            end while (ok);
          end
          if ($urandom_range(0, 9) == 0) begin
            sh = seg_tab[$urandom_range(0, 9)];
            m_step(s, sh, 1, nv, ne);
            r = '{s, sh, 1, m_p1, m_p2, m_lk, nv, ne};
            run_row(r, $sformatf("rnd f%0d short", f));
          end
          len = $urandom_range(5, 8);
          m_step(s, g, len, nv, ne);
          r = '{s, g, len, m_p1, m_p2, m_lk, nv, ne};
          run_row(r, $sformatf("rnd f%0d r%0d s%0d", f, rp, sl));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
